// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the two-source operand/data bus arbiter.
package cpu_bus_pkg;

    localparam int DW = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_OWN0 = ST_OWN0,
        S_OWN1 = ST_OWN1
    } arb_state_t;

endpackage

// File: rtl/bus_arbiter2_mux.sv
// 8-bit 2:1 data selector: ctrl=0 passes a, ctrl=1 passes b.
module bus_arbiter2_mux
    import cpu_bus_pkg::*;
(
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic          ctrl,
    output logic [DW-1:0] y
);

    assign y = ctrl ? b : a;

endmodule

// File: rtl/bus_arbiter2.sv
// Round-robin two-source bus arbiter with req/gnt/rel handshake, hold watchdog
// and a registered bus byte.
//
// state  | meaning
// S_IDLE | nobody owns the bus, bus_vld drops next cycle
// S_OWN0 | source 0 owns the bus, d0 is captured each edge
// S_OWN1 | source 1 owns the bus, d1 is captured each edge
module bus_arbiter2
    import cpu_bus_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    req,
    input  logic [1:0]    rel,
    input  logic [DW-1:0] d0,
    input  logic [DW-1:0] d1,
    output logic [1:0]    gnt,
    output logic          sel,
    output logic [DW-1:0] bus_d,
    output logic          bus_vld,
    output logic          timeout
);

    localparam int CW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] HOLD_LAST = (MAX_HOLD < 1) ? '0 : CW'(MAX_HOLD - 1);

    arb_state_t    state, state_nxt;
    logic          last_owner, last_owner_nxt;
    logic [CW-1:0] hold_cnt;
    logic          wd_hit;
    logic          wd_exit;
    logic          entering;
    logic [DW-1:0] mux_y;

    assign wd_hit   = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
    assign entering = (state_nxt != S_IDLE) && (state_nxt != state);

    always_comb begin
        state_nxt      = state;
        last_owner_nxt = last_owner;
        wd_exit        = 1'b0;
        case (state)
            S_IDLE: begin
                if (req == 2'b11)
                    state_nxt = last_owner ? S_OWN0 : S_OWN1;
                else if (req[0])
                    state_nxt = S_OWN0;
                else if (req[1])
                    state_nxt = S_OWN1;
            end
            S_OWN0: begin
                if (rel[0] || !req[0] || wd_hit) begin
                    last_owner_nxt = 1'b0;
                    wd_exit        = wd_hit;
                    state_nxt      = req[1] ? S_OWN1 : S_IDLE;
                end
            end
            S_OWN1: begin
                if (rel[1] || !req[1] || wd_hit) begin
                    last_owner_nxt = 1'b1;
                    wd_exit        = wd_hit;
                    state_nxt      = req[0] ? S_OWN0 : S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            last_owner <= 1'b1;
            timeout    <= 1'b0;
            sel        <= 1'b0;
            hold_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            last_owner <= last_owner_nxt;
            timeout    <= wd_exit;
            if (entering) begin
                hold_cnt <= '0;
                sel      <= (state_nxt == S_OWN1);
            end else if (state == S_IDLE) begin
                hold_cnt <= '0;
            end else if (hold_cnt != '1) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

    // sel tracks the owner throughout OWN, so the mux output is the owner's byte
    bus_arbiter2_mux u_mux (
        .a    (d0),
        .b    (d1),
        .ctrl (sel),
        .y    (mux_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_d   <= '0;
            bus_vld <= 1'b0;
        end else if (state != S_IDLE) begin
            bus_d   <= mux_y;
            bus_vld <= 1'b1;
        end else begin
            bus_vld <= 1'b0;
        end
    end

    assign gnt = {state == S_OWN1, state == S_OWN0};

endmodule

// File: tb/tb_bus_arbiter2.sv
// Self-checking bench for bus_arbiter2: directed vector table, async reset
// sequence, then randomized traffic against a behavioural model.
module tb_bus_arbiter2;

    localparam int MAX_HOLD = 4;

    logic       clk;
    logic       rst_n;
    logic [1:0] req;
    logic [1:0] rel;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [1:0] gnt;
    logic       sel;
    logic [7:0] bus_d;
    logic       bus_vld;
    logic       timeout;

    int n_checks = 0;
    int n_errors = 0;

    bus_arbiter2 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .rel     (rel),
        .d0      (d0),
        .d1      (d1),
        .gnt     (gnt),
        .sel     (sel),
        .bus_d   (bus_d),
        .bus_vld (bus_vld),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: owner is -1 when idle, age counts edges spent owning.
    int         m_own;
    int         m_age;
    int         m_last;
    logic       m_sel;
    logic [7:0] m_bus;
    logic       m_vld;
    logic       m_to;

    task automatic model_reset();
        m_own  = -1;
        m_age  = 0;
        m_last = 1;
        m_sel  = 1'b0;
        m_bus  = 8'h00;
        m_vld  = 1'b0;
        m_to   = 1'b0;
    endtask

    task automatic model_step();
        int nown;
        int other;
        bit wd;
        nown = m_own;
        m_to = 1'b0;
        if (m_own >= 0) begin
            m_vld = 1'b1;
            m_bus = (m_own == 1) ? d1 : d0;
        end else begin
            m_vld = 1'b0;
        end
        if (m_own < 0) begin
            if (req == 2'b11) nown = 1 - m_last;
            else if (req[0])  nown = 0;
            else if (req[1])  nown = 1;
            else              nown = -1;
        end else begin
            other = 1 - m_own;
            wd = (MAX_HOLD != 0) && (m_age == MAX_HOLD - 1);
            if (rel[m_own] || !req[m_own] || wd) begin
                m_last = m_own;
                m_to   = wd;
                nown   = req[other] ? other : -1;
            end
        end
        if (nown >= 0 && nown != m_own) begin
            m_age = 0;
            m_sel = (nown == 1);
        end else if (nown >= 0) begin
            m_age = m_age + 1;
        end
        m_own = nown;
    endtask

    function automatic logic [1:0] model_gnt();
        if (m_own == 0) return 2'b01;
        if (m_own == 1) return 2'b10;
        return 2'b00;
    endfunction

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %02h expected %02h", name, $time, got, exp);
        end
    endtask

    task automatic cyc(input logic [1:0] rq, input logic [1:0] rl,
                       input logic [7:0] a, input logic [7:0] b);
        req = rq;
        rel = rl;
        d0  = a;
        d1  = b;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = 2'b00; rel = 2'b00; d0 = 8'h00; d1 = 8'h00;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [1:0] req;
        logic [1:0] rel;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [1:0] gnt;
        logic       sel;
        logic [7:0] bus_d;
        logic       vld;
        logic       to;
    } vec_t;

    vec_t tbl[23];

    initial begin
        // inputs applied before an edge, outputs expected just after it
        tbl[0]  = '{2'b11, 2'b00, 8'hA5, 8'h3C, 2'b01, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[1]  = '{2'b11, 2'b01, 8'hA5, 8'h3C, 2'b10, 1'b1, 8'hA5, 1'b1, 1'b0};
        tbl[2]  = '{2'b11, 2'b00, 8'hA5, 8'h3C, 2'b10, 1'b1, 8'h3C, 1'b1, 1'b0};
        tbl[3]  = '{2'b11, 2'b10, 8'hA5, 8'h3C, 2'b01, 1'b0, 8'h3C, 1'b1, 1'b0};
        tbl[4]  = '{2'b01, 2'b10, 8'hA5, 8'h3C, 2'b01, 1'b0, 8'hA5, 1'b1, 1'b0};
        tbl[5]  = '{2'b00, 2'b00, 8'hA5, 8'h3C, 2'b00, 1'b0, 8'hA5, 1'b1, 1'b0};
        tbl[6]  = '{2'b00, 2'b00, 8'hA5, 8'h3C, 2'b00, 1'b0, 8'hA5, 1'b0, 1'b0};
        tbl[7]  = '{2'b11, 2'b00, 8'h5A, 8'hC3, 2'b10, 1'b1, 8'hA5, 1'b0, 1'b0};
        tbl[8]  = '{2'b10, 2'b10, 8'h5A, 8'hC3, 2'b00, 1'b1, 8'hC3, 1'b1, 1'b0};
        tbl[9]  = '{2'b00, 2'b00, 8'h5A, 8'hC3, 2'b00, 1'b1, 8'hC3, 1'b0, 1'b0};
        tbl[10] = '{2'b01, 2'b00, 8'h11, 8'hC3, 2'b01, 1'b0, 8'hC3, 1'b0, 1'b0};
        tbl[11] = '{2'b01, 2'b00, 8'h11, 8'hC3, 2'b01, 1'b0, 8'h11, 1'b1, 1'b0};
        tbl[12] = '{2'b01, 2'b00, 8'h11, 8'hC3, 2'b01, 1'b0, 8'h11, 1'b1, 1'b0};
        tbl[13] = '{2'b01, 2'b00, 8'h11, 8'hC3, 2'b01, 1'b0, 8'h11, 1'b1, 1'b0};
        tbl[14] = '{2'b01, 2'b00, 8'h11, 8'hC3, 2'b00, 1'b0, 8'h11, 1'b1, 1'b1};
        tbl[15] = '{2'b01, 2'b00, 8'h11, 8'hC3, 2'b01, 1'b0, 8'h11, 1'b0, 1'b0};
        tbl[16] = '{2'b00, 2'b00, 8'h11, 8'hC3, 2'b00, 1'b0, 8'h11, 1'b1, 1'b0};
        tbl[17] = '{2'b11, 2'b00, 8'h11, 8'h77, 2'b10, 1'b1, 8'h11, 1'b0, 1'b0};
        tbl[18] = '{2'b11, 2'b00, 8'h11, 8'h77, 2'b10, 1'b1, 8'h77, 1'b1, 1'b0};
        tbl[19] = '{2'b11, 2'b00, 8'h11, 8'h77, 2'b10, 1'b1, 8'h77, 1'b1, 1'b0};
        tbl[20] = '{2'b11, 2'b00, 8'h11, 8'h77, 2'b10, 1'b1, 8'h77, 1'b1, 1'b0};
        tbl[21] = '{2'b11, 2'b00, 8'h11, 8'h77, 2'b01, 1'b0, 8'h77, 1'b1, 1'b1};
        tbl[22] = '{2'b00, 2'b00, 8'h11, 8'h77, 2'b00, 1'b0, 8'h11, 1'b1, 1'b0};

        rst_n = 1'b0;
        req = 2'b00; rel = 2'b00; d0 = 8'h00; d1 = 8'h00;
        #2;
        check("rst_gnt",     {6'b0, gnt},     8'h00);
        check("rst_sel",     {7'b0, sel},     8'h00);
        check("rst_bus_d",   bus_d,           8'h00);
        check("rst_vld",     {7'b0, bus_vld}, 8'h00);
        check("rst_timeout", {7'b0, timeout}, 8'h00);
        do_reset();

        for (int i = 0; i < 23; i++) begin
            cyc(tbl[i].req, tbl[i].rel, tbl[i].d0, tbl[i].d1);
            check($sformatf("tbl%0d_gnt", i),   {6'b0, gnt},     {6'b0, tbl[i].gnt});
            check($sformatf("tbl%0d_sel", i),   {7'b0, sel},     {7'b0, tbl[i].sel});
            check($sformatf("tbl%0d_bus_d", i), bus_d,           tbl[i].bus_d);
            check($sformatf("tbl%0d_vld", i),   {7'b0, bus_vld}, {7'b0, tbl[i].vld});
            check($sformatf("tbl%0d_to", i),    {7'b0, timeout}, {7'b0, tbl[i].to});
        end

        // asynchronous reset while source 1 owns with valid data on the bus
        do_reset();
        cyc(2'b10, 2'b00, 8'h00, 8'h3C);
        cyc(2'b10, 2'b00, 8'h00, 8'h3C);
        check("pre_rst_gnt", {6'b0, gnt},     8'h02);
        check("pre_rst_vld", {7'b0, bus_vld}, 8'h01);
        check("pre_rst_bus", bus_d,           8'h3C);
        #2 rst_n = 1'b0;
        #1;
        check("async_gnt",   {6'b0, gnt},     8'h00);
        check("async_sel",   {7'b0, sel},     8'h00);
        check("async_bus_d", bus_d,           8'h00);
        check("async_vld",   {7'b0, bus_vld}, 8'h00);
        #3 rst_n = 1'b1;
        model_reset();
        cyc(2'b11, 2'b00, 8'h5A, 8'h3C);
        check("post_rst_tie_gnt", {6'b0, gnt}, 8'h01);
        check("post_rst_tie_sel", {7'b0, sel}, 8'h00);

        // randomized traffic against the model
        do_reset();
        begin
            logic [1:0] rq;
            logic [1:0] rl;
            rq = 2'b00;
            for (int k = 0; k < 3000; k++) begin
                if ($urandom_range(0, 3) == 0) rq = 2'($urandom_range(0, 3));
                rl = 2'b00;
                if ($urandom_range(0, 5) == 0) rl = 2'($urandom_range(1, 3));
                cyc(rq, rl, 8'($urandom), 8'($urandom));
                check("rnd_gnt",   {6'b0, gnt},     {6'b0, model_gnt()});
                check("rnd_sel",   {7'b0, sel},     {7'b0, m_sel});
                check("rnd_bus_d", bus_d,           m_bus);
                check("rnd_vld",   {7'b0, bus_vld}, {7'b0, m_vld});
                check("rnd_to",    {7'b0, timeout}, {7'b0, m_to});
                if (gnt == 2'b11) begin
                    n_errors++;
                    $display("FAIL rnd_onehot at %0t: got gnt=%b expected not 11", $time, gnt);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter2.md
Name: bus_arbiter2

Overview:
Two-requester arbiter that shares the 8-bit operand/data bus between two sources, such as the register file and the immediate/memory path.
- Grants ownership with a req/gnt/rel handshake and drives the 2:1 8-bit selector control.
- Registers the selected byte onto the bus with a valid flag.
- Uses round-robin fairness and a hold-time watchdog so that neither source can starve the other.

Parameters:
MAX_HOLD, 8, max consecutive cycles one requester may own the bus; 0 disables the watchdog.
CW, $clog2(MAX_HOLD+1) (minimum 1), hold counter width (derived; not overridden).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
req  input  2  request per source; bit i = source i; level, held while ownership is wanted.
rel  input  2  release per source; single-cycle pulse, honoured only from the current owner.
d0  input  8  source 0 data.
d1  input  8  source 1 data.
gnt  output  2  one-hot grant, registered; 00 when idle.
sel  output  1  selector control (0 = d0, 1 = d1); equals current owner, holds last owner when idle.
bus_d  output  8  registered bus data.
bus_vld  output  1  bus_d valid this cycle.
timeout  output  1  one-cycle pulse when the watchdog revokes a grant.

Behaviour:
- One clock (clk); reset is asynchronous, active-low (rst_n).
- Reset, asserted at any time including mid-ownership, clears immediately:
  - state=IDLE, gnt=00, sel=0, bus_d=00h, bus_vld=0, timeout=0.
  - hold counter=0, last_owner=1, so source 0 wins the first tie.
- States: IDLE, OWN0, OWN1. gnt[i]=1 exactly when state==OWNi.
- IDLE:
  - req==00: stay.
  - Exactly one request: go to that OWN next edge.
  - Both requesting: go to OWN of the source != last_owner.
  - Grant latency: 1 cycle from req sampled high to gnt high.
- OWNi exits on the first edge where any of these holds:
  - (a) rel[i]=1.
  - (b) req[i]=0.
  - (c) MAX_HOLD!=0 and the hold counter == MAX_HOLD-1; this case also pulses timeout=1 for the next cycle.
- Exit target:
  - If req[other]=1: OWN(other) directly, zero dead cycles. gnt switches one-hot in a single edge and never shows 11.
  - Otherwise: IDLE.
  - After a watchdog exit with no other request, the source passes through IDLE for at least 1 cycle before it may be re-granted.
- last_owner updates to i on every exit from OWNi.
- Hold counter:
  - Clears on entry to any OWN state.
  - Increments each cycle in OWN and saturates (no wrap).
  - Is held at 0 in IDLE.
- rel from a non-owner, or during IDLE: ignored. rel and req drop in the same cycle: a single exit.
- Data path:
  - Selection through the existing 8-bit 2:1 MUX block with ctrl=sel.
  - Each edge where state==OWNi: bus_d <= d_i, bus_vld <= 1. One cycle latency from gnt to data.
  - Otherwise: bus_vld <= 0, and bus_d holds its value.
  - The cycle in which OWNi is exited still captures d_i.
- sel:
  - Registered alongside gnt.
  - Changes only on entry to an OWN state.
  - Never toggles while bus_vld of the same owner is pending.
- timeout is 0 in all cycles except the single cycle after a watchdog revocation.

Decomposition:
- Shared package, cpu_bus_pkg:
  - State encoding constants ST_IDLE=2'd0, ST_OWN0=2'd1, ST_OWN1=2'd2.
  - Data width constant DW=8.
- One sub-module: the existing 8-bit 2:1 MUX, instantiated once for data selection.
- FSM, counter and output registers stay in bus_arbiter2.

Test Plan:
- Reset then req=01, d0=A5h, rel0 pulsed on cycle 4 -> gnt=01 at cycle 1, sel=0, bus_d=A5h with bus_vld=1 from cycle 2, gnt=00 after cycle 4, bus_vld=0 the cycle after.
- Tie, req=11 from IDLE after reset -> gnt=01 first. Source 0 releases -> gnt=10 on the next edge, no IDLE gap, sel=1, bus_d=d1=3Ch, gnt never 11.
- Tie again after source 1 last owned -> source 0 granted. Repeat with source 0 as last owner -> source 1 granted, alternating 01/10.
- MAX_HOLD=4, req=01 held, rel never pulsed -> gnt=01 for exactly 4 cycles, timeout=1 for one cycle, gnt=00 for at least 1 cycle, then gnt=01 again.
- rel=10 pulsed while source 0 owns -> ignored, gnt stays 01. req0 drops -> exit to IDLE (or OWN1 if req1=1).
- rst_n low mid-OWN1 with bus_vld=1 -> gnt=00, sel=0, bus_d=00h, bus_vld=0 immediately, without waiting for clk. After release with req=11 -> source 0 granted.
